// File: rtl/mux_pkg.sv
// Shared constants for the N:1 registered multiplexer family.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer
// moves past the winner whenever an enabled grant is issued.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] idx,
    output logic            any
);

    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [SELW-1:0] ptr;
    int              j;

    // Walk offsets from the far end so the one closest to ptr is kept last.
    always_comb begin
        any = 1'b0;
        idx = '0;
        gnt = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                any = 1'b1;
                idx = SELW'(j);
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr <= '0;
        end else if (en && any) begin
            ptr <= (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_n_rr.sv
// N:1 registered datapath mux with valid/ready on every channel and on the
// output; channel chosen by explicit index or by round-robin.
module mux_n_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [N*WIDTH-1:0]   D,
    input  logic [N-1:0]         V,
    output logic [N-1:0]         RDY,
    input  logic                 MODE,
    input  logic [SELW-1:0]      S,
    output logic [WIDTH-1:0]     O,
    output logic                 OV,
    input  logic                 ORDY,
    output logic [SELW-1:0]      OSEL
);

    logic            free;
    logic            ld;
    logic            sel_ok;
    logic            rr_any;
    logic [SELW-1:0] rr_idx;
    logic [N-1:0]    rr_gnt;
    logic            g_any;
    logic [SELW-1:0] g_idx;
    logic [WIDTH-1:0] g_data;

    assign free = !OV || ORDY;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req   (V),
        .en    (free && (MODE == MODE_RR) && RST_N),
        .gnt   (rr_gnt),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // Compare against each legal index so an out-of-range S never grants.
    always_comb begin
        sel_ok = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (S == SELW'(i) && V[i]) sel_ok = 1'b1;
        end
    end

    assign g_any = (MODE == MODE_RR) ? rr_any : sel_ok;
    assign g_idx = (MODE == MODE_RR) ? rr_idx : S;
    assign ld    = RST_N && free && g_any;

    always_comb begin
        g_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g_idx == SELW'(i)) g_data = D[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        RDY = '0;
        if (ld) begin
            if (MODE == MODE_RR) begin
                RDY = rr_gnt;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (S == SELW'(i)) RDY[i] = 1'b1;
                end
            end
        end
    end

    // Output stage: load on grant, otherwise drop valid once drained.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            O    <= '0;
            OV   <= 1'b0;
            OSEL <= '0;
        end else if (ld) begin
            O    <= g_data;
            OV   <= 1'b1;
            OSEL <= g_idx;
        end else if (OV && ORDY) begin
            OV   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_rr.sv
// Bench for mux_n_rr: directed scenarios plus random traffic against a
// cycle-level reference model of the selection rules.
module tb_mux_n_rr;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic [N*WIDTH-1:0]   D;
    logic [N-1:0]         V;
    logic [N-1:0]         RDY;
    logic                 MODE;
    logic [SELW-1:0]      S;
    logic [WIDTH-1:0]     O;
    logic                 OV;
    logic                 ORDY;
    logic [SELW-1:0]      OSEL;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] m_o;
    logic             m_ov;
    int               m_osel;
    int               m_ptr;

    mux_n_rr #(.WIDTH(WIDTH), .N(N)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .D    (D),
        .V    (V),
        .RDY  (RDY),
        .MODE (MODE),
        .S    (S),
        .O    (O),
        .OV   (OV),
        .ORDY (ORDY),
        .OSEL (OSEL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Which channel the rules say is granted this cycle, -1 for none.
    function automatic int model_grant();
        if (m_ov && !ORDY) return -1;
        if (MODE == 1'b0) begin
            if (int'(S) < N && V[S]) return int'(S);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (V[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Inputs are set just after a rising edge; this checks RDY, then the
    // registered outputs after the next edge.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge CLK);
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("rdy", RDY, exp_rdy);
        @(posedge CLK);
        if (g >= 0) begin
            m_o    = D[g*WIDTH +: WIDTH];
            m_osel = g;
            m_ov   = 1'b1;
            if (MODE) m_ptr = (g + 1) % N;
        end else if (m_ov && ORDY) begin
            m_ov = 1'b0;
        end
        #1;
        check("o", O, m_o);
        check("ov", OV, m_ov);
        check("osel", OSEL, m_osel);
    endtask

    task automatic model_reset();
        m_o = '0; m_ov = 1'b0; m_osel = 0; m_ptr = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_o"}, O, 0);
        check({tag, "_ov"}, OV, 0);
        check({tag, "_osel"}, OSEL, 0);
        check({tag, "_rdy"}, RDY, 0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        model_reset();
        #1;
        check_reset_state("rst");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic set_ch(input int i, input logic [WIDTH-1:0] val);
        D[i*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        D = '0; V = 4'hF; MODE = 1'b1; S = '0; ORDY = 1'b1;

        // Reset, then first round-robin load from channel 0
        do_reset();
        set_ch(0, 16'h1111);
        cycle();
        check("t1_o", O, 16'h1111);
        check("t1_osel", OSEL, 0);
        check("t1_ov", OV, 1);

        // Explicit select
        MODE = 1'b0; S = 2'd2; V = 4'b0100; set_ch(2, 16'hBEEF);
        cycle();
        check("t2_o", O, 16'hBEEF);
        check("t2_osel", OSEL, 2);
        S = 2'd3;
        cycle();
        check("t2_drain_ov", OV, 0);

        // Round-robin fairness from a fresh pointer
        do_reset();
        MODE = 1'b1; V = 4'hF; ORDY = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, WIDTH'(i));
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t3_osel", OSEL, k % N);
            check("t3_o", O, k % N);
        end
        V = 4'b1001;
        cycle();
        check("t3_skip3", OSEL, 3);
        cycle();
        check("t3_skip0", OSEL, 0);

        // Backpressure holds the output and the pointer
        V = 4'hF;
        for (int i = 0; i < N; i++) set_ch(i, 16'hA5A5);
        cycle();
        check("t4_load", O, 16'hA5A5);
        ORDY = 1'b0;
        for (int i = 0; i < N; i++) set_ch(i, 16'h5000 + WIDTH'(i));
        repeat (3) begin
            cycle();
            check("t4_hold_o", O, 16'hA5A5);
            check("t4_hold_ov", OV, 1);
        end
        ORDY = 1'b1;
        cycle();
        check("t4_nobubble_ov", OV, 1);
        check("t4_new_o", O, 16'h5002);

        // Explicit loads leave the round-robin pointer alone
        do_reset();
        MODE = 1'b1; V = 4'hF; ORDY = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 16'hC000 + WIDTH'(i));
        cycle(); cycle();
        MODE = 1'b0; S = 2'd0;
        cycle(); cycle();
        check("t5_sel_osel", OSEL, 0);
        MODE = 1'b1;
        cycle();
        check("t5_rr_resume", OSEL, 2);

        // Asynchronous reset with a stalled word in the output register
        ORDY = 1'b0;
        cycle();
        check("t6_stall_ov", OV, 1);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check_reset_state("t6");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        V = 4'hF; MODE = 1'b1; ORDY = 1'b1;
        cycle();
        check("t6_first", OSEL, 0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            D    = {$urandom, $urandom};
            V    = N'($urandom);
            MODE = 1'($urandom);
            S    = SELW'($urandom);
            ORDY = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
